pipeline_hazard_unit: RTL

//  Hazard detection and forwarding control for the pipelined MIPS core, generalised in pipeline depth.
//  - Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//  - Tracks in-flight destination registers; drives forwarding selects for rs/rt.
//  - Drives stall, bubble and flush controls.
//  - Counts stall cycles for performance monitoring.

---
 rtl/pipeline_hazard_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard detection and forwarding control for a pipelined MIPS core, with a
//   configurable number of tracked stages after ID.
//   The unit keeps a shadow record {vld, wr, ld, wreg} for every in-flight
//   instruction in stages 1..STAGES (1 = EX, STAGES = WB). Each cycle it
//   compares the ID-stage sources against those records and decides on
//   forwarding, stalling, bubbling and flushing in the same cycle.
//
// Configuration macro: HAZARD_FORWARDING_EN
//   defined   : the youngest matching stage is forwarded; only a load that is
//               still younger than LOAD_STAGE stalls.
//   undefined : no forwarding (selects tied to 0). Any match stalls, because
//               the register file writes on the WB edge, so a same-cycle read
//               returns stale data.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rs/id_rt         ID source registers, qualified by id_uses_rs/id_uses_rt
//   id_regwrite/id_wreg ID destination (after RegDst/JAL mux)
//   id_memread          ID instruction is a load
//   branch_taken        control transfer resolved taken in EX this cycle
//   ext_stall           memory busy; entire pipeline freezes
//   stall_if_id         hold PC and IF/ID
//   bubble_id_ex        load a NOP into ID/EX
//   flush_if_id         clear IF/ID
//   fwd_rs_sel/rt_sel   0 = register file, k = forward from stage k
//   stall_count         saturating count of cycles with stall_if_id=1

// Per-stage comparator: does this stage's record feed an ID source?
module pipeline_hazard_unit_match #(
  parameter int ADDR_W = 5
) (
  input  logic              vld,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wreg,
  input  logic              id_valid,
  input  logic              uses_rs,
  input  logic [ADDR_W-1:0] rs,
  input  logic              uses_rt,
  input  logic [ADDR_W-1:0] rt,
  output logic              hit_rs,
  output logic              hit_rt
);
  logic live;

  // $0 is hard-wired to zero, so it can never be a real dependency.
  assign live   = id_valid & vld & wr;
  assign hit_rs = live & uses_rs & (rs != '0) & (wreg == rs);
  assign hit_rt = live & uses_rt & (rt != '0) & (wreg == rt);
endmodule

module pipeline_hazard_unit #(
  parameter  int ADDR_W     = 5,
  parameter  int STAGES     = 3,
  parameter  int LOAD_STAGE = 2,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_regwrite,
  input  logic [ADDR_W-1:0] id_wreg,
  input  logic              id_memread,
  input  logic              branch_taken,
  input  logic              ext_stall,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [CNT_W-1:0]  stall_count
);
  localparam logic [SEL_W-1:0] LOAD_K = SEL_W'(LOAD_STAGE);

  // In-flight records, index k = stage k after ID.
  logic [STAGES:1]             rec_vld, rec_wr, rec_ld;
  logic [STAGES:1][ADDR_W-1:0] rec_wreg;
  logic [STAGES:1]             hit_rs, hit_rt;

  logic [SEL_W-1:0] rs_k, rt_k;
  logic             rs_ld, rt_ld;
  logic             any_rs, any_rt;
  logic             lu_rs, lu_rt;
  logic             hazard;
  logic [SEL_W-1:0] rs_fwd, rt_fwd;

  // ---------------------------------------------------------------------
  // Match array
  // ---------------------------------------------------------------------
  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    pipeline_hazard_unit_match #(.ADDR_W(ADDR_W)) u_match (
      .vld      (rec_vld[g]),
      .wr       (rec_wr[g]),
      .wreg     (rec_wreg[g]),
      .id_valid (id_valid),
      .uses_rs  (id_uses_rs),
      .rs       (id_rs),
      .uses_rt  (id_uses_rt),
      .rt       (id_rt),
      .hit_rs   (hit_rs[g]),
      .hit_rt   (hit_rt[g])
    );
  end

  // Youngest match wins: scan old-to-young so the smallest k is written last.
  // The ld bit is taken from that same youngest stage, so an older match can
  // never mask a younger load.
  always_comb begin
    rs_k  = '0;
    rt_k  = '0;
    rs_ld = 1'b0;
    rt_ld = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (hit_rs[k]) begin
        rs_k  = SEL_W'(k);
        rs_ld = rec_ld[k];
      end
      if (hit_rt[k]) begin
        rt_k  = SEL_W'(k);
        rt_ld = rec_ld[k];
      end
    end
  end

  assign any_rs = |hit_rs;
  assign any_rt = |hit_rt;

  // Load data is not available before LOAD_STAGE.
  assign lu_rs = any_rs & rs_ld & (rs_k < LOAD_K);
  assign lu_rt = any_rt & rt_ld & (rt_k < LOAD_K);

`ifdef HAZARD_FORWARDING_EN
  assign hazard = lu_rs | lu_rt;
  // A stalled instruction will re-evaluate next cycle; do not forward now.
  assign rs_fwd = hazard ? '0 : rs_k;
  assign rt_fwd = hazard ? '0 : rt_k;
`else
  // Every dependency stalls until the writer retires; load-use is a subset.
  assign hazard = any_rs | any_rt | lu_rs | lu_rt;
  assign rs_fwd = '0;
  assign rt_fwd = '0;
`endif

  // ---------------------------------------------------------------------
  // Control decision (priority: reset, ext_stall, branch, hazard)
  // ---------------------------------------------------------------------
  always_comb begin
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (reset) begin
      stall_if_id = 1'b0;
    end else if (ext_stall) begin
      stall_if_id = 1'b1;
    end else if (branch_taken) begin
      // The ID instruction is on the wrong path: kill it instead of stalling.
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (hazard) begin
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  assign fwd_rs_sel = reset ? '0 : rs_fwd;
  assign fwd_rt_sel = reset ? '0 : rt_fwd;

  // ---------------------------------------------------------------------
  // Record shift chain; frozen while memory is busy
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_vld  <= '0;
      rec_wr   <= '0;
      rec_ld   <= '0;
      rec_wreg <= '0;
    end else if (!ext_stall) begin
      for (int k = STAGES; k >= 2; k--) begin
        rec_vld[k]  <= rec_vld[k-1];
        rec_wr[k]   <= rec_wr[k-1];
        rec_ld[k]   <= rec_ld[k-1];
        rec_wreg[k] <= rec_wreg[k-1];
      end
      if (id_valid && !bubble_id_ex) begin
        rec_vld[1]  <= 1'b1;
        rec_wr[1]   <= id_regwrite;
        rec_ld[1]   <= id_memread;
        rec_wreg[1] <= id_wreg;
      end else begin
        rec_vld[1]  <= 1'b0;
        rec_wr[1]   <= 1'b0;
        rec_ld[1]   <= 1'b0;
        rec_wreg[1] <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Saturating stall counter (external stalls included)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_if_id && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
endmodule
